serial_unloader: RTL and testbench

- Reads a parallel word, such as the 4-bit operand/result word held in the team's load registers, and shifts it out one bit per accepted handshake.
- Consumer side of the parallel load path: the register captures a word on load, and this block captures a word on start and drains it serially toward a bit-serial adder stage or an LED/debug output.
- Uses a valid/ready handshake on the serial side and start/busy/done on the parallel side.

---
 rtl/serial_unloader_pkg.sv | 16 +
 rtl/serial_unloader_shift_out_reg.sv | 55 +++++
 rtl/serial_unloader.sv | 113 +++++++++++
 tb/tb_serial_unloader.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_unloader_pkg.sv
// rtl/serial_unloader_pkg.sv - shared word width and FSM state encoding for the serial unloader
// Purpose: constants shared with the parallel load register and the unloader FSM.
// Ports: none (package).
package serial_unloader_pkg;

    // Word width shared with the parallel load register.
    localparam int unsigned DEFAULT_WIDTH = 4;

    // 2'b11 is unreachable; the FSM treats it as ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/serial_unloader_shift_out_reg.sv
// rtl/serial_unloader_shift_out_reg.sv - shadow register with parallel load and directional shift
// Purpose: holds the captured word and shifts it toward the output end, zero-filling.
// Ports:
//   clock_i    rising-edge clock
//   resetn_i   synchronous active-low reset, clears the shadow
//   load_i     capture data_i (has priority over shift_i)
//   data_i     parallel word to capture
//   shift_i    advance one bit toward the output end
//   bit_o      bit currently at the output end
module serial_unloader_shift_out_reg
    import serial_unloader_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic             clock_i,
    input  logic             resetn_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             shift_i,
    output logic             bit_o
);

    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] shadow_d;
    logic [WIDTH-1:0] shifted;

    // Zero-fill means the shadow is all zeros once a full word has drained,
    // so bit_o reads 0 in IDLE and DONE without extra gating.
    if (LSB_FIRST) begin : g_lsb
        assign shifted = {1'b0, shadow_q[WIDTH-1:1]};
        assign bit_o   = shadow_q[0];
    end else begin : g_msb
        assign shifted = {shadow_q[WIDTH-2:0], 1'b0};
        assign bit_o   = shadow_q[WIDTH-1];
    end

    always_comb begin
        shadow_d = shadow_q;
        if (load_i) begin
            shadow_d = data_i;
        end else if (shift_i) begin
            shadow_d = shifted;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!resetn_i) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end

endmodule

// File: rtl/serial_unloader.sv
// rtl/serial_unloader.sv - captures a parallel word on start and drains it one bit per handshake
// Purpose: parallel-to-serial unloader with start/busy/done control and valid/ready output.
// Ports:
//   clock       rising-edge clock
//   reset       synchronous active-low reset
//   R           parallel word, sampled on the accepting start cycle
//   start       capture request, honoured only when idle
//   sout        current serial bit
//   sout_valid  sout holds a valid bit
//   sout_ready  downstream accepts sout this cycle
//   busy        high from the cycle after start until DONE completes
//   done        one-cycle pulse after the last bit is accepted
module serial_unloader
    import serial_unloader_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] R,
    input  logic             start,
    output logic             sout,
    output logic             sout_valid,
    input  logic             sout_ready,
    output logic             busy,
    output logic             done
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    state_e           state_eff;
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             load;
    logic             shift;

    always_comb begin
        // Fold the unused encoding onto IDLE.
        state_eff = (state_q == ST_SHIFT || state_q == ST_DONE) ? state_q : ST_IDLE;
        state_d   = state_eff;
        count_d   = count_q;
        load      = 1'b0;
        shift     = 1'b0;
        case (state_eff)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    count_d = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (sout_ready) begin
                    shift = 1'b1;
                    // Hold the counter on the last bit so it never wraps.
                    if (count_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Outputs are registered as a decode of the next state.
        valid_d = (state_d == ST_SHIFT);
        busy_d  = (state_d == ST_SHIFT) || (state_d == ST_DONE);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    serial_unloader_shift_out_reg #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_shift_out_reg (
        .clock_i  (clock),
        .resetn_i (reset),
        .load_i   (load),
        .data_i   (R),
        .shift_i  (shift),
        .bit_o    (sout)
    );

    assign sout_valid = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_serial_unloader.sv
// tb/tb_serial_unloader.sv - self-checking bench for serial_unloader (LSB-first and MSB-first instances)
module tb_serial_unloader;

    localparam int W = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] R = '0;
    logic         start = 1'b0;
    logic         sout_ready = 1'b0;

    logic sout_l, sv_l, busy_l, done_l;
    logic sout_m, sv_m, busy_m, done_m;

    serial_unloader #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
        .clock(clock), .reset(reset), .R(R), .start(start),
        .sout(sout_l), .sout_valid(sv_l), .sout_ready(sout_ready),
        .busy(busy_l), .done(done_l)
    );

    serial_unloader #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
        .clock(clock), .reset(reset), .R(R), .start(start),
        .sout(sout_m), .sout_valid(sv_m), .sout_ready(sout_ready),
        .busy(busy_m), .done(done_m)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: captured word, bits still to deliver, pending done pulse.
    logic [W-1:0] m_word [2] = '{'0, '0};
    int           m_left [2] = '{0, 0};
    bit           m_done [2] = '{1'b0, 1'b0};
    bit           m_live = 1'b0;

    always @(posedge clock) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                m_left[i] = 0;
                m_done[i] = 1'b0;
                m_word[i] = '0;
            end else if (m_done[i]) begin
                m_done[i] = 1'b0;
            end else if (m_left[i] > 0) begin
                if (sout_ready) begin
                    m_left[i] = m_left[i] - 1;
                    if (m_left[i] == 0) m_done[i] = 1'b1;
                end
            end else if (start) begin
                m_word[i] = R;
                m_left[i] = W;
            end
        end
        if (!reset) m_live = 1'b1;
    end

    // {sout, valid, busy, done} as the model requires them.
    function automatic logic [3:0] expect_out(int i);
        int   k;
        logic b;
        logic v;
        v = (m_left[i] > 0);
        k = W - m_left[i];
        b = 1'b0;
        if (v) b = (i == 0) ? m_word[i][k] : m_word[i][W-1-k];
        return {b, v, v || m_done[i], m_done[i]};
    endfunction

    logic [3:0]  obs [2];
    logic [3:0]  exp_o;
    logic [15:0] acc_log [2] = '{'0, '0};
    int          acc_tot [2] = '{0, 0};
    int          done_tot[2] = '{0, 0};
    int          busy_tot[2] = '{0, 0};

    string       lit_name = "";
    logic [31:0] lit_act = '0;
    logic [31:0] lit_exp = '0;
    int          lit_seq = 0;
    int          lit_seen = 0;

    always @(negedge clock) begin
        obs[0] = {sout_l, sv_l, busy_l, done_l};
        obs[1] = {sout_m, sv_m, busy_m, done_m};
        if (m_live) begin
            for (int i = 0; i < 2; i++) begin
                exp_o = expect_out(i);
                total++;
                if (obs[i] !== exp_o) begin
                    bad++;
                    $display("FAIL cycle %0d inst%0d sout/valid/busy/done got %b need %b",
                             cyc, i, obs[i], exp_o);
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (obs[i][2] && sout_ready) begin
                acc_log[i] = {acc_log[i][14:0], obs[i][3]};
                acc_tot[i]++;
            end
            if (obs[i][0]) done_tot[i]++;
            if (obs[i][1]) busy_tot[i]++;
        end
        if (lit_seq != lit_seen) begin
            total++;
            if (lit_act !== lit_exp) begin
                bad++;
                $display("FAIL %s got %0h need %0h", lit_name, lit_act, lit_exp);
            end
            lit_seen = lit_seq;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic lit(input string n, input logic [31:0] a, input logic [31:0] e);
        lit_name = n;
        lit_act  = a;
        lit_exp  = e;
        lit_seq++;
        @(negedge clock);
        #1;
    endtask

    task automatic do_start(input logic [W-1:0] r);
        R     = r;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    int s_acc [2];
    int s_done[2];
    int s_busy[2];

    task automatic snap();
        for (int i = 0; i < 2; i++) begin
            s_acc[i]  = acc_tot[i];
            s_done[i] = done_tot[i];
            s_busy[i] = busy_tot[i];
        end
    endtask

    int          pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    logic [2:0]  lat;
    logic [7:0]  outs;
    logic [7:0]  outs2;
    int          mid;

    initial begin
        // Reset state
        reset = 1'b0;
        repeat (3) step();
        lit("reset_outs", {24'd0, sout_l, sv_l, busy_l, done_l, sout_m, sv_m, busy_m, done_m}, 0);
        reset = 1'b1;
        sout_ready = 1'b1;
        step();

        // Tests 1 and 2: R=1011, ready held high
        snap();
        do_start(4'b1011);
        lat = {sv_l, sout_l, sout_m};
        repeat (7) step();
        lit("t1_latency", {29'd0, lat}, 3'b111);
        lit("t1_bits", {28'd0, acc_log[0][3:0]}, 4'b1101);
        lit("t2_bits", {28'd0, acc_log[1][3:0]}, 4'b1011);
        lit("t1_acc", acc_tot[0] - s_acc[0], 4);
        lit("t1_done", done_tot[0] - s_done[0], 1);
        lit("t1_busy", busy_tot[0] - s_busy[0], 5);
        lit("t2_done", done_tot[1] - s_done[1], 1);

        // Test 3: stalls
        snap();
        do_start(4'b0110);
        for (int k = 0; k < 7; k++) begin
            sout_ready = pat[k][0];
            step();
        end
        sout_ready = 1'b1;
        repeat (4) step();
        lit("t3_bits_lsb", {28'd0, acc_log[0][3:0]}, 4'b0110);
        lit("t3_bits_msb", {28'd0, acc_log[1][3:0]}, 4'b0110);
        lit("t3_acc", acc_tot[0] - s_acc[0], 4);
        lit("t3_done", done_tot[0] - s_done[0], 1);

        // Test 4: start during SHIFT is ignored
        snap();
        do_start(4'b0001);
        step();
        R = 4'b1111;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        lit("t4_bits_lsb", {28'd0, acc_log[0][3:0]}, 4'b1000);
        lit("t4_bits_msb", {28'd0, acc_log[1][3:0]}, 4'b0001);
        lit("t4_acc", acc_tot[0] - s_acc[0], 4);
        lit("t4_done", done_tot[0] - s_done[0], 1);
        snap();
        do_start(4'b1111);
        repeat (6) step();
        lit("t4_fresh_bits", {28'd0, acc_log[0][3:0]}, 4'b1111);
        lit("t4_fresh_acc", acc_tot[1] - s_acc[1], 4);

        // Test 5: reset mid-transfer
        snap();
        do_start(4'b1011);
        step();
        step();
        mid = acc_tot[0] - s_acc[0];
        reset = 1'b0;
        step();
        outs = {sout_l, sv_l, busy_l, done_l, sout_m, sv_m, busy_m, done_m};
        reset = 1'b1;
        repeat (6) step();
        lit("t5_mid_acc", mid, 2);
        lit("t5_after_reset", {24'd0, outs}, 0);
        lit("t5_no_done", done_tot[0] - s_done[0], 0);
        snap();
        do_start(4'b1011);
        repeat (6) step();
        lit("t5_restart_lsb", {28'd0, acc_log[0][3:0]}, 4'b1101);
        lit("t5_restart_msb", {28'd0, acc_log[1][3:0]}, 4'b1011);
        lit("t5_restart_done", done_tot[0] - s_done[0], 1);

        // Test 6: reset beats start; R changes after capture
        reset = 1'b0;
        start = 1'b1;
        R = 4'b1111;
        step();
        outs = {sout_l, sv_l, busy_l, done_l, sout_m, sv_m, busy_m, done_m};
        reset = 1'b1;
        start = 1'b0;
        step();
        outs2 = {sout_l, sv_l, busy_l, done_l, sout_m, sv_m, busy_m, done_m};
        lit("t6_reset_wins", {24'd0, outs}, 0);
        lit("t6_still_idle", {24'd0, outs2}, 0);
        snap();
        do_start(4'b1100);
        R = 4'b0110;
        step();
        R = W'($urandom);
        repeat (6) step();
        lit("t6_bits_lsb", {28'd0, acc_log[0][3:0]}, 4'b0011);
        lit("t6_bits_msb", {28'd0, acc_log[1][3:0]}, 4'b1100);

        // Randomized traffic against the model
        repeat (3000) begin
            R          = W'($urandom);
            start      = ($urandom_range(0, 3) == 0);
            sout_ready = ($urandom_range(0, 3) != 0);
            reset      = ($urandom_range(0, 60) != 0);
            step();
        end
        reset = 1'b1;
        start = 1'b0;
        sout_ready = 1'b1;
        repeat (10) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
